// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_pkg : state encodings and default sizes shared by the game sequencer, |
// |            the VGA renderer and the seven-segment display.                 |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package game_pkg;

  localparam int DEF_NUM_BLOCKS  = 50;
  localparam int DEF_INIT_HEALTH = 3;

  localparam logic [1:0] GS_BEGIN = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_WIN   = 2'b11;
  localparam logic [1:0] GS_LOSE  = 2'b10;

  // Low two bits are the externally visible game_state; bit 2 marks PAUSE.
  typedef logic [2:0] state_t;

  localparam state_t ST_BEGIN = {1'b0, GS_BEGIN};
  localparam state_t ST_PLAY  = {1'b0, GS_PLAY};
  localparam state_t ST_PAUSE = {1'b1, GS_PLAY};
  localparam state_t ST_WIN   = {1'b0, GS_WIN};
  localparam state_t ST_LOSE  = {1'b0, GS_LOSE};

endpackage
`default_nettype wire

// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_flow_ctrl_if : player inputs toward the sequencer and the registered  |
// |                     game status back to renderer/display.                  |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface game_flow_ctrl_if #(
  parameter int NUM_BLOCKS = game_pkg::DEF_NUM_BLOCKS
);
  logic                  start_btn;
  logic                  pause_btn;
  logic                  hit;
  logic                  touch_valid;
  logic [5:0]            touch_idx;
  logic [1:0]            game_state;
  logic [3:0]            health;
  logic [NUM_BLOCKS-1:0] bk_touched;
  logic                  paused;
  logic                  invuln;

  modport master (
    output start_btn, pause_btn, hit, touch_valid, touch_idx,
    input  game_state, health, bk_touched, paused, invuln
  );

  modport slave (
    input  start_btn, pause_btn, hit, touch_valid, touch_idx,
    output game_state, health, bk_touched, paused, invuln
  );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl_btn_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_edge : rising-edge detector on a debounced button level.               |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module btn_edge (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic btn,
  output logic      rise
);
  logic r_prev;

  // Previous sample resets high so a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b1;
    else       r_prev <= btn;
  end

  assign rise = btn & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_flow_ctrl : game state machine, health, block scoreboard and         |
// |                  post-hit invulnerability window.                         |
// | Option   : GAME_PAUSE_EN builds the PAUSE state and pause edge detector.  |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_BLOCKS      = DEF_NUM_BLOCKS,
  parameter int INIT_HEALTH     = DEF_INIT_HEALTH,
  parameter int INVULN_CYCLES   = 25_000_000,
  parameter int END_HOLD_CYCLES = 150_000_000
) (
  input wire logic        clk,
  input wire logic        reset,
  game_flow_ctrl_if.slave bus
);
  localparam int INV_W  = (INVULN_CYCLES < 1) ? 1 : $clog2(INVULN_CYCLES + 1);
  localparam int HOLD_W = (END_HOLD_CYCLES < 2) ? 1 : $clog2(END_HOLD_CYCLES);

  localparam logic [INV_W-1:0]      c_INV_LOAD    = INV_W'(INVULN_CYCLES);
  localparam logic [HOLD_W-1:0]     c_HOLD_LAST   = HOLD_W'(END_HOLD_CYCLES - 1);
  localparam logic [3:0]            c_INIT_HEALTH = 4'(INIT_HEALTH);
  localparam logic [NUM_BLOCKS-1:0] c_ALL_BLOCKS  = '1;

  state_t                r_state,   w_state_next;
  logic [3:0]            r_health,  w_health_next;
  logic [NUM_BLOCKS-1:0] r_bk,      w_bk_next;
  logic [INV_W-1:0]      r_inv_cnt, w_inv_cnt_next;
  logic [HOLD_W-1:0]     r_hold,    w_hold_next;
  logic                  r_invuln;
  logic                  w_start_rise;
  logic                  w_pause_rise;

  btn_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.start_btn),
    .rise  (w_start_rise)
  );

`ifdef GAME_PAUSE_EN
  btn_edge u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.pause_btn),
    .rise  (w_pause_rise)
  );
`else
  logic w_unused_pause;
  assign w_pause_rise   = 1'b0;
  assign w_unused_pause = bus.pause_btn ^ r_state[2];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_BEGIN;
      r_health  <= c_INIT_HEALTH;
      r_bk      <= '0;
      r_inv_cnt <= '0;
      r_hold    <= '0;
      r_invuln  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_health  <= w_health_next;
      r_bk      <= w_bk_next;
      r_inv_cnt <= w_inv_cnt_next;
      r_hold    <= w_hold_next;
      r_invuln  <= (w_inv_cnt_next != '0);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_health_next  = r_health;
    w_bk_next      = r_bk;
    w_inv_cnt_next = r_inv_cnt;
    w_hold_next    = '0;
    case (r_state)
      ST_BEGIN: begin
        w_health_next  = c_INIT_HEALTH;
        w_bk_next      = '0;
        w_inv_cnt_next = '0;
        if (w_start_rise) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_pause_rise) begin
          w_state_next = ST_PAUSE;
        end else begin
          if (r_inv_cnt != '0) w_inv_cnt_next = r_inv_cnt - INV_W'(1);
          if (bus.hit && (r_inv_cnt == '0)) begin
            w_inv_cnt_next = c_INV_LOAD;
            if (r_health != 4'd0) w_health_next = r_health - 4'd1;
          end
          if (bus.touch_valid && (int'(bus.touch_idx) < NUM_BLOCKS))
            w_bk_next[bus.touch_idx] = 1'b1;
          // A final touch landing with the final hit still counts as a win.
          if (w_bk_next == c_ALL_BLOCKS) w_state_next = ST_WIN;
          else if (w_health_next == 4'd0) w_state_next = ST_LOSE;
        end
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (w_pause_rise) w_state_next = ST_PLAY;
      end
`endif
      ST_WIN, ST_LOSE: begin
        if (r_inv_cnt != '0) w_inv_cnt_next = r_inv_cnt - INV_W'(1);
        if (w_start_rise || (r_hold == c_HOLD_LAST)) begin
          w_state_next   = ST_BEGIN;
          w_health_next  = c_INIT_HEALTH;
          w_bk_next      = '0;
          w_inv_cnt_next = '0;
        end else begin
          w_hold_next = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_next = ST_BEGIN;
    endcase
  end

  always_comb begin
    bus.game_state = r_state[1:0];
    bus.health     = r_health;
    bus.bk_touched = r_bk;
    bus.invuln     = r_invuln;
`ifdef GAME_PAUSE_EN
    bus.paused     = r_state[2];
`else
    bus.paused     = 1'b0;
`endif
  end
endmodule
`default_nettype wire
